// File: rtl/handshake_ctrl.sv
// Multi-channel start/finish handshake controller: one independent FSM per router port.
// Define HS_TIMEOUT_EN to enable the bounded-BUSY timeout (counters, TOUT state, timeout pulse).
module handshake_ctrl #(
  parameter int N_CH           = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [N_CH-1:0]           start,
  input  logic [N_CH-1:0]           finish,
  input  logic [N_CH-1:0]           result,
  output logic [N_CH-1:0]           ready,
  output logic [N_CH-1:0]           accept,
  output logic [N_CH-1:0]           timeout,
  output logic [N_CH-1:0]           proto_err,
  output logic [$clog2(N_CH+1)-1:0] busy_cnt
);

  localparam int BW = $clog2(N_CH+1);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("handshake_ctrl: N_CH must be 1..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("handshake_ctrl: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } state_e;

  // Per-channel state is kept visible for checkers bound to this module.
  state_e          state_q [N_CH];
  state_e          state_d [N_CH];
  logic [N_CH-1:0] ready_d, accept_d, perr_d;
  logic [BW-1:0]   busy_d;

`ifdef HS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]         tout_q, tout_d;
  assign timeout = tout_q;
`else
  assign timeout = '0;
`endif

  // Handshake: a channel is ready while IDLE/DONE/TOUT; start (level) opens a
  // transaction, finish closes it, and accept mirrors result while it is live.
  always_comb begin
    ready_d  = ready;
    accept_d = accept;
    perr_d   = proto_err;
    busy_d   = '0;
`ifdef HS_TIMEOUT_EN
    cnt_d    = cnt_q;
    tout_d   = '0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      if (!enable) begin
        state_d[i]  = IDLE;
        ready_d[i]  = 1'b1;
        accept_d[i] = 1'b0;
`ifdef HS_TIMEOUT_EN
        cnt_d[i]    = '0;
`endif
      end else begin
        case (state_q[i])
          IDLE, DONE: begin
            if (start[i] && !finish[i]) begin
              state_d[i]  = BUSY;
              ready_d[i]  = 1'b0;
              accept_d[i] = result[i];
`ifdef HS_TIMEOUT_EN
              cnt_d[i]    = '0;
`endif
            end else if (start[i] && finish[i]) begin
              state_d[i]  = DONE;
              ready_d[i]  = 1'b1;
              accept_d[i] = result[i];
            end else begin
              state_d[i]  = IDLE;
              ready_d[i]  = 1'b1;
              accept_d[i] = 1'b0;
              if (finish[i]) perr_d[i] = 1'b1;
            end
          end
          BUSY: begin
            if (finish[i]) begin
              state_d[i]  = DONE;
              ready_d[i]  = 1'b1;
              accept_d[i] = result[i];
            end else if (!start[i]) begin
              state_d[i]  = IDLE;
              ready_d[i]  = 1'b1;
              accept_d[i] = 1'b0;
`ifdef HS_TIMEOUT_EN
            end else if (cnt_q[i] == CNT_MAX) begin
              state_d[i]  = TOUT;
              ready_d[i]  = 1'b1;
              accept_d[i] = 1'b0;
              tout_d[i]   = 1'b1;
`endif
            end else begin
              state_d[i]  = BUSY;
              ready_d[i]  = 1'b0;
              accept_d[i] = result[i];
`ifdef HS_TIMEOUT_EN
              cnt_d[i]    = cnt_q[i] + 1'b1;
`endif
            end
          end
`ifdef HS_TIMEOUT_EN
          // A timed-out channel waits for start to fall; finish is ignored here.
          TOUT: begin
            ready_d[i]  = 1'b1;
            accept_d[i] = 1'b0;
            if (!start[i]) state_d[i] = IDLE;
          end
`endif
          default: begin
            state_d[i]  = IDLE;
            ready_d[i]  = 1'b1;
            accept_d[i] = 1'b0;
          end
        endcase
      end
      busy_d = busy_d + BW'(state_d[i] == BUSY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= IDLE;
      ready     <= '1;
      accept    <= '0;
      proto_err <= '0;
      busy_cnt  <= '0;
`ifdef HS_TIMEOUT_EN
      cnt_q     <= '0;
      tout_q    <= '0;
`endif
    end else begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= state_d[i];
      ready     <= ready_d;
      accept    <= accept_d;
      proto_err <= perr_d;
      busy_cnt  <= busy_d;
`ifdef HS_TIMEOUT_EN
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
`endif
    end
  end

endmodule

// File: tb/tb_handshake_ctrl.sv
// Directed bench for handshake_ctrl (N_CH=5, TIMEOUT_CYCLES=4); adapts to HS_TIMEOUT_EN.
module tb_handshake_ctrl;

  localparam int N_CH = 5;
  localparam int TC   = 4;
  localparam int BW   = $clog2(N_CH+1);

  logic            clk = 1'b0;
  logic            rst, enable;
  logic [N_CH-1:0] start, finish, result;
  logic [N_CH-1:0] ready, accept, timeout, proto_err;
  logic [BW-1:0]   busy_cnt;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic            en;
    logic [N_CH-1:0] s, f, r;
    logic [N_CH-1:0] rdy, acc, to, pe;
    logic [BW-1:0]   bc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  handshake_ctrl #(.N_CH(N_CH), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .start(start), .finish(finish), .result(result),
    .ready(ready), .accept(accept), .timeout(timeout),
    .proto_err(proto_err), .busy_cnt(busy_cnt)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic en, input logic [N_CH-1:0] s, f, r);
    enable = en; start = s; finish = f; result = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [N_CH-1:0] rdy, acc, to, pe,
                           input logic [BW-1:0] bc);
    check({tag, ".ready"},     ready,     rdy);
    check({tag, ".accept"},    accept,    acc);
    check({tag, ".timeout"},   timeout,   to);
    check({tag, ".proto_err"}, proto_err, pe);
    check({tag, ".busy_cnt"},  busy_cnt,  bc);
  endtask

  task automatic add(input logic en, input logic [N_CH-1:0] s, f, r,
                     input logic [N_CH-1:0] rdy, acc, to, pe, input logic [BW-1:0] bc);
    vec_t v;
    v.en = en; v.s = s; v.f = f; v.r = r;
    v.rdy = rdy; v.acc = acc; v.to = to; v.pe = pe; v.bc = bc;
    vecs.push_back(v);
  endtask

  initial begin
    // Channel 0 normal transaction, then back-to-back DONE -> BUSY
    add(1, 5'b00001, 5'b00000, 5'b00001, 5'b11110, 5'b00001, 0, 5'b00000, 1);
    add(1, 5'b00001, 5'b00000, 5'b00001, 5'b11110, 5'b00001, 0, 5'b00000, 1);
    add(1, 5'b00001, 5'b00000, 5'b00001, 5'b11110, 5'b00001, 0, 5'b00000, 1);
    add(1, 5'b00001, 5'b00001, 5'b00001, 5'b11111, 5'b00001, 0, 5'b00000, 0);
    add(1, 5'b00000, 5'b00000, 5'b00001, 5'b11111, 5'b00000, 0, 5'b00000, 0);
    add(1, 5'b00001, 5'b00001, 5'b00001, 5'b11111, 5'b00001, 0, 5'b00000, 0);
    add(1, 5'b00001, 5'b00000, 5'b00000, 5'b11110, 5'b00000, 0, 5'b00000, 1);
    add(1, 5'b00001, 5'b00001, 5'b00001, 5'b11111, 5'b00001, 0, 5'b00000, 0);
    add(1, 5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 5'b00000, 0);
    // Protocol error on channel 1
    add(1, 5'b00000, 5'b00010, 5'b00010, 5'b11111, 5'b00000, 0, 5'b00010, 0);
    // Concurrency on channels 0, 2, 4
    add(1, 5'b10101, 5'b00000, 5'b10100, 5'b01010, 5'b10100, 0, 5'b00010, 3);
    add(1, 5'b10101, 5'b00001, 5'b10101, 5'b01011, 5'b10101, 0, 5'b00010, 2);
    add(1, 5'b10100, 5'b00000, 5'b00100, 5'b01011, 5'b00100, 0, 5'b00010, 2);
    add(1, 5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 5'b00010, 0);
    // Enable drop mid-BUSY on channel 3, then re-enable with start3 held
    add(1, 5'b01000, 5'b00000, 5'b01000, 5'b10111, 5'b01000, 0, 5'b00010, 1);
    add(1, 5'b01000, 5'b00000, 5'b01000, 5'b10111, 5'b01000, 0, 5'b00010, 1);
    add(0, 5'b01000, 5'b01010, 5'b11111, 5'b11111, 5'b00000, 0, 5'b00010, 0);
    add(0, 5'b01000, 5'b01010, 5'b11111, 5'b11111, 5'b00000, 0, 5'b00010, 0);
    add(1, 5'b01000, 5'b00000, 5'b01000, 5'b10111, 5'b01000, 0, 5'b00010, 1);
    add(1, 5'b01000, 5'b00000, 5'b01000, 5'b10111, 5'b01000, 0, 5'b00010, 1);
    add(1, 5'b01000, 5'b00000, 5'b01000, 5'b10111, 5'b01000, 0, 5'b00010, 1);
    add(1, 5'b01000, 5'b00000, 5'b01000, 5'b10111, 5'b01000, 0, 5'b00010, 1);
`ifdef HS_TIMEOUT_EN
    add(1, 5'b01000, 5'b00000, 5'b01000, 5'b11111, 5'b00000, 5'b01000, 5'b00010, 0);
    add(1, 5'b01000, 5'b00000, 5'b01000, 5'b11111, 5'b00000, 5'b00000, 5'b00010, 0);
`else
    add(1, 5'b01000, 5'b00000, 5'b01000, 5'b10111, 5'b01000, 0, 5'b00010, 1);
    add(1, 5'b01000, 5'b00000, 5'b01000, 5'b10111, 5'b01000, 0, 5'b00010, 1);
`endif
    add(1, 5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 0, 5'b00010, 0);

    // Reset with random inputs
    rst = 1'b1;
    drive(1'($urandom_range(1, 0)), N_CH'($urandom), N_CH'($urandom), N_CH'($urandom));
    step();
    drive(1'($urandom_range(1, 0)), N_CH'($urandom), N_CH'($urandom), N_CH'($urandom));
    step();
    check_all("reset", 5'b11111, 0, 0, 0, 0);
    rst = 1'b0;
    drive(1, 0, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].en, vecs[k].s, vecs[k].f, vecs[k].r);
      step();
      check_all($sformatf("vec%0d", k), vecs[k].rdy, vecs[k].acc, vecs[k].to, vecs[k].pe, vecs[k].bc);
    end

`ifdef HS_TIMEOUT_EN
    // Channel 2 held in start: BUSY for TC cycles, one timeout pulse, finish ignored in TOUT
    for (int i = 0; i < 10; i++) begin
      drive(1, 5'b00100, (i >= 5) ? 5'b00100 : 5'b00000, 5'b00100);
      step();
      check($sformatf("tout%0d.ready2", i),   ready[2],   (i < TC) ? 0 : 1);
      check($sformatf("tout%0d.accept2", i),  accept[2],  (i < TC) ? 1 : 0);
      check($sformatf("tout%0d.timeout2", i), timeout[2], (i == TC) ? 1 : 0);
      check($sformatf("tout%0d.busy_cnt", i), busy_cnt,   (i < TC) ? 1 : 0);
      check($sformatf("tout%0d.proto_err", i), proto_err, 5'b00010);
    end
    drive(1, 0, 0, 0);
    step();
    check_all("tout_exit", 5'b11111, 0, 0, 5'b00010, 0);
    drive(1, 5'b00100, 0, 5'b00100);
    step();
    check_all("tout_reenter", 5'b11011, 5'b00100, 0, 5'b00010, 1);
`else
    // Without the timeout feature BUSY is unbounded
    for (int i = 0; i < 20; i++) begin
      drive(1, 5'b00100, 0, 5'b00100);
      step();
      check($sformatf("unbounded%0d.ready2", i), ready[2], 0);
      check($sformatf("unbounded%0d.timeout", i), timeout, 0);
    end
    drive(1, 5'b00100, 5'b00100, 5'b00100);
    step();
    check_all("unbounded_done", 5'b11111, 5'b00100, 0, 5'b00010, 0);
`endif
    drive(1, 0, 0, 0);
    step();
    check_all("idle_again", 5'b11111, 0, 0, 5'b00010, 0);

    // Reset mid-transaction clears proto_err and discards BUSY without a pulse
    drive(1, 5'b00001, 0, 5'b00001);
    step();
    check_all("pre_rst_busy", 5'b11110, 5'b00001, 0, 5'b00010, 1);
    rst = 1'b1;
    step();
    check_all("mid_rst", 5'b11111, 0, 0, 0, 0);
    rst = 1'b0;
    drive(1, 0, 0, 0);
    step();
    check_all("post_rst", 5'b11111, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/handshake_ctrl.md
# handshake_ctrl

Parametrised multi-channel start/finish handshake controller for the NoC 3x3 router ports. Each channel runs an independent state machine that drives `ready` and `accept` from the `start`/`finish`/`result` handshake. It adds a bounded-busy timeout, a protocol-error flag and a busy-channel count. One instance serves all ports of a router node.

## Interface
- `N_CH`, default 5: number of independent channels (N, E, S, W, local); legal range 1..16.
- `TIMEOUT_CYCLES`, default 16: maximum consecutive cycles a channel may stay BUSY; legal minimum 2.

Ports:
- `clk`  in  1  clock; all logic updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  global enable; when low, every channel is forced to IDLE.
- `start`  in  N_CH  per-channel transaction start (level).
- `finish`  in  N_CH  per-channel transaction finish (level).
- `result`  in  N_CH  per-channel accept verdict from the downstream checker.
- `ready`  out  N_CH  channel idle and able to take a new start.
- `accept`  out  N_CH  registered copy of `result` while a transaction is live or completing.
- `timeout`  out  N_CH  one-cycle pulse when a channel's BUSY period expires.
- `proto_err`  out  N_CH  sticky flag: `finish` was sampled high while the channel was IDLE with `start` low.
- `busy_cnt`  out  $clog2(N_CH+1)  number of channels currently in BUSY.

## Operation
- Per-channel states: IDLE, BUSY, DONE, TOUT. All outputs are registered and are functions of the state entered at the edge.
- IDLE and DONE use the same exit rules, evaluated in this priority order:
  - `start`=1, `finish`=0: go to BUSY; ready<=0; accept<=result; counter<=0.
  - `start`=1, `finish`=1: go to DONE (single-cycle transaction); ready<=1; accept<=result.
  - `start`=0, `finish`=1: go to IDLE; ready<=1; accept<=0; proto_err<=1.
  - Otherwise: go to IDLE; ready<=1; accept<=0.
- BUSY, evaluated in this priority order:
  - `finish`=1: go to DONE; ready<=1; accept<=result. Finish takes priority over timeout at the same edge.
  - `start`=0: abort to IDLE; ready<=1; accept<=0.
  - Counter == TIMEOUT_CYCLES-1: go to TOUT; ready<=1; accept<=0; timeout<=1.
  - Otherwise: stay in BUSY; accept<=result; counter<=counter+1.
- TOUT:
  - Holds ready=1, accept=0.
  - `start` is ignored until it is sampled low; the channel then goes to IDLE.
  - `finish` seen in TOUT is ignored and does not set `proto_err`.
- `timeout` is high only in the first cycle after entering TOUT.
- Counter width is $clog2(TIMEOUT_CYCLES); it never wraps.
- `busy_cnt` is the population count of next-state==BUSY, registered on the same edge as the state.
- `enable`=0 (with `rst`=0):
  - All channels go to IDLE; ready=1, accept=0, timeout=0, counters=0, busy_cnt=0.
  - `proto_err` keeps its value.
  - Inputs are ignored.
- `rst`=1 has priority over `enable`. Every channel goes to IDLE; ready=all ones, accept=0, timeout=0, proto_err=0, busy_cnt=0. Reset applied mid-transaction discards the transaction without a timeout pulse.

## Timing
- Latency: inputs sampled at edge k appear on outputs after edge k; one cycle, no combinational paths from input to output.
- BUSY lasts at most TIMEOUT_CYCLES cycles. Example with TIMEOUT_CYCLES=4: start sampled at edge 0 gives ready=0 for edges 0..3, and edge 4 enters TOUT with timeout=1.
- DONE lasts exactly one cycle unless a new start&finish re-enters it.
- Back-to-back transactions are allowed: DONE followed by start=1, finish=0 enters BUSY on the next edge with no idle cycle.
- Channels are fully independent; simultaneous events on different channels do not interact except through `busy_cnt`.

## Configuration
- Macro: `HS_TIMEOUT_EN`.
- Defined: counters, the TOUT state and the `timeout` output are live as described above.
- Undefined:
  - No counters and no TOUT state; BUSY is unbounded and exits only on finish or abort.
  - `timeout` is tied to 0.
  - `TIMEOUT_CYCLES` is unused.
- All other behaviour is identical in both builds.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs -> ready=5'b11111, accept=0, timeout=0, proto_err=0, busy_cnt=0.
- Channel 0 normal transaction: start=1, finish=0 for 3 cycles with result=1, then start=1, finish=1 -> ready0=0 for 3 cycles, accept0=1 throughout, DONE for 1 cycle with ready0=1, then IDLE with accept0=0.
- Timeout (TIMEOUT_CYCLES=4, macro defined): start2 held high, finish2=0 for 10 cycles -> timeout2 pulses once after edge 4, ready2=1, and no re-entry into BUSY until start2 drops.
- Protocol error: finish1=1, start1=0 in IDLE -> proto_err1=1 next cycle; it stays 1 through enable=0 and clears only on rst.
- Concurrency: start=5'b10101 at the same edge -> busy_cnt=3 next cycle; finish0=1 one cycle later -> busy_cnt=2.
- Enable drop mid-BUSY on channel 3 -> next cycle ready3=1, accept3=0, busy_cnt=0, no timeout pulse; re-enable with start3 high -> BUSY again with the counter restarted at 0.
